point_cal_stream: RTL and testbench

Parametrised successor to the fixed four-point sample-point generator. From a centre point (xc, yc) and a boundary point (xb, yb), it derives the direction angle and its cos/sin. It then streams NPTS sample points along that direction, one per beat, on each side of the boundary point (or the outer side only). The block sits between the contour/boundary extractor and the matching stage, with valid/ready on both sides.

---
 rtl/point_cal_pkg.sv | 42 ++++
 rtl/point_cal_stream_dir.sv | 65 ++++++
 rtl/point_cal_stream.sv | 151 +++++++++++++++
 tb/tb_point_cal_stream.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/point_cal_pkg.sv
// Shared types and helpers for the point calibration stream: FSM states,
// coefficient scaling, beat counting and the octant atan/cos/sin tables.
package point_cal_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ANGLE, ST_EMIT} state_t;

    localparam int unsigned COEF_FRAC = 8;

    function automatic int unsigned beats(input logic mode, input int unsigned npts);
        return mode ? npts : 2 * npts;
    endfunction

    // tan() at the midpoints between 5.625-degree steps, scaled by 256
    function automatic logic [7:0] atan_thr(input int unsigned i);
        case (i)
            0:       return 8'd13;
            1:       return 8'd38;
            2:       return 8'd64;
            3:       return 8'd92;
            4:       return 8'd121;
            5:       return 8'd153;
            6:       return 8'd190;
            default: return 8'd232;
        endcase
    endfunction

    // cos/sin magnitude of t*5.625 degrees (t = 0..8), 1.0 = 256
    function automatic logic [8:0] trig_oct(input logic [3:0] t, input logic iscos);
        case (t)
            4'd0:    return iscos ? 9'd256 : 9'd0;
            4'd1:    return iscos ? 9'd255 : 9'd25;
            4'd2:    return iscos ? 9'd251 : 9'd50;
            4'd3:    return iscos ? 9'd245 : 9'd74;
            4'd4:    return iscos ? 9'd237 : 9'd98;
            4'd5:    return iscos ? 9'd226 : 9'd121;
            4'd6:    return iscos ? 9'd213 : 9'd142;
            4'd7:    return iscos ? 9'd198 : 9'd162;
            default: return 9'd181;
        endcase
    endfunction

endpackage

// File: rtl/point_cal_stream_dir.sv
// Direction unit: four-stage pipeline from (dx, dy) to signed cos/sin of the
// direction angle, quantised to 5.625-degree steps via octant folding.
module point_dir_unit
    import point_cal_pkg::*;
#(
    parameter int unsigned COEF_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               i_dx,
    input  logic [9:0]               i_dy,
    output logic signed [COEF_W-1:0] o_cos,
    output logic signed [COEF_W-1:0] o_sin
);

    logic [9:0]               r1_ax, r1_ay, r2_mx, r2_mn;
    logic                     r1_sx, r1_sy, r2_sx, r2_sy, r2_swap, r3_sx, r3_sy, r3_swap;
    logic [3:0]               r3_t, w_t;
    logic [8:0]               w_cmag, w_smag;
    logic signed [COEF_W-1:0] w_cos, w_sin;

    // atan: count how many step midpoints the ratio mn/mx has passed
    always_comb begin
        w_t = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ({r2_mn, 8'd0} >= 18'(r2_mx) * 18'(atan_thr(i)))
                w_t = w_t + 4'd1;
        end
    end

    always_comb begin
        w_cmag = r3_swap ? trig_oct(r3_t, 1'b0) : trig_oct(r3_t, 1'b1);
        w_smag = r3_swap ? trig_oct(r3_t, 1'b1) : trig_oct(r3_t, 1'b0);
        w_cos  = COEF_W'(w_cmag);
        w_sin  = COEF_W'(w_smag);
        if (r3_sx) w_cos = -w_cos;
        if (r3_sy) w_sin = -w_sin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_ax <= '0; r1_ay <= '0; r1_sx <= 1'b0; r1_sy <= 1'b0;
            r2_mx <= '0; r2_mn <= '0; r2_swap <= 1'b0; r2_sx <= 1'b0; r2_sy <= 1'b0;
            r3_t <= '0; r3_swap <= 1'b0; r3_sx <= 1'b0; r3_sy <= 1'b0;
            o_cos <= '0; o_sin <= '0;
        end else begin
            r1_ax   <= i_dx[9] ? (~i_dx + 10'd1) : i_dx;
            r1_ay   <= i_dy[9] ? (~i_dy + 10'd1) : i_dy;
            r1_sx   <= i_dx[9];
            r1_sy   <= i_dy[9];
            r2_swap <= r1_ay > r1_ax;
            r2_mx   <= (r1_ay > r1_ax) ? r1_ay : r1_ax;
            r2_mn   <= (r1_ay > r1_ax) ? r1_ax : r1_ay;
            r2_sx   <= r1_sx;
            r2_sy   <= r1_sy;
            r3_t    <= w_t;
            r3_swap <= r2_swap;
            r3_sx   <= r2_sx;
            r3_sy   <= r2_sy;
            o_cos   <= w_cos;
            o_sin   <= w_sin;
        end
    end

endmodule

// File: rtl/point_cal_stream.sv
// Streams NPTS sample points per side along the centre-to-boundary direction,
// one registered beat per valid/ready handshake.
module point_cal_stream
    import point_cal_pkg::*;
#(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned NPTS     = 4,
    parameter int unsigned STEP     = 3,
    parameter int unsigned COEF_W   = 10,
    parameter int unsigned TRIG_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           xc,
    input  logic [WIDTH-1:0]           yc,
    input  logic [WIDTH-1:0]           xb,
    input  logic [WIDTH-1:0]           yb,
    input  logic                       mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_x,
    output logic [WIDTH-1:0]           out_y,
    output logic [$clog2(NPTS+1)-1:0]  out_idx,
    output logic                       out_side,
    output logic                       out_last,
    output logic                       busy
);

    localparam int unsigned ACC_W = COEF_W + $clog2(NPTS * STEP + 1) + 1;
    localparam int unsigned IDX_W = $clog2(NPTS + 1);
    localparam int unsigned BW    = $clog2(2 * NPTS + 1);
    localparam int unsigned CW    = $clog2(TRIG_LAT + 1);
    localparam logic signed [ACC_W-1:0] STEP_S = ACC_W'(STEP);

    state_t                      r_state, w_state_nxt;
    logic [WIDTH-1:0]            r_xc, r_yc, r_xb, r_yb, r_x, r_y;
    logic [WIDTH-1:0]            w_dx, w_dy, w_off_x, w_off_y, w_x_nxt, w_y_nxt;
    logic                        r_mode, r_valid, r_side, r_last;
    logic [CW-1:0]               r_cnt;
    logic signed [COEF_W-1:0]    r_cos, r_sin, w_dir_cos, w_dir_sin, w_coef_c, w_coef_s;
    logic signed [ACC_W-1:0]     r_acc_c, r_acc_s, w_acc_c_nxt, w_acc_s_nxt;
    logic signed [ACC_W+WIDTH-1:0] w_ext_c, w_ext_s;
    logic [IDX_W-1:0]            r_k, w_k_nxt;
    logic [BW-1:0]               r_beat, w_beat_nxt;
    logic                        w_side_nxt, w_last_nxt, w_new_k, w_zero;
    logic                        w_angle_done, w_fire, w_load;

    assign w_dx = r_xb - r_xc;
    assign w_dy = r_yb - r_yc;
    assign w_zero = (w_dx == '0) && (w_dy == '0);

    point_dir_unit #(.COEF_W(COEF_W)) u_dir (
        .clk  (clk),
        .rst  (rst),
        .i_dx (w_dx[WIDTH-1 -: 10]),
        .i_dy (w_dy[WIDTH-1 -: 10]),
        .o_cos(w_dir_cos),
        .o_sin(w_dir_sin)
    );

    assign w_angle_done = (r_state == ST_ANGLE) && (r_cnt == CW'(TRIG_LAT));
    assign w_fire       = r_valid && out_ready;
    assign w_load       = w_angle_done || ((r_state == ST_EMIT) && w_fire && !r_last);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_state_nxt = ST_ANGLE;
            ST_ANGLE: if (w_angle_done) w_state_nxt = ST_EMIT;
            ST_EMIT:  if (w_fire && r_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Next beat is built from the captured coefficients, or straight from the
    // direction unit on the ANGLE->EMIT edge so the first beat has no bubble.
    always_comb begin
        w_coef_c    = w_angle_done ? (w_zero ? '0 : w_dir_cos) : r_cos;
        w_coef_s    = w_angle_done ? (w_zero ? '0 : w_dir_sin) : r_sin;
        w_new_k     = w_angle_done || r_mode || !r_side;
        w_acc_c_nxt = r_acc_c;
        w_acc_s_nxt = r_acc_s;
        if (w_new_k) begin
            w_acc_c_nxt = (w_angle_done ? '0 : r_acc_c) + ACC_W'(w_coef_c) * STEP_S;
            w_acc_s_nxt = (w_angle_done ? '0 : r_acc_s) + ACC_W'(w_coef_s) * STEP_S;
        end
        w_ext_c    = (ACC_W + WIDTH)'(w_acc_c_nxt) >>> COEF_FRAC;
        w_ext_s    = (ACC_W + WIDTH)'(w_acc_s_nxt) >>> COEF_FRAC;
        w_off_x    = w_ext_c[WIDTH-1:0];
        w_off_y    = w_ext_s[WIDTH-1:0];
        w_side_nxt = w_angle_done || r_mode || !r_side;
        w_k_nxt    = w_angle_done ? IDX_W'(1) : (w_new_k ? r_k + IDX_W'(1) : r_k);
        w_beat_nxt = w_angle_done ? '0 : r_beat + BW'(1);
        w_last_nxt = (w_beat_nxt == BW'(beats(r_mode, NPTS) - 1));
        w_x_nxt    = w_side_nxt ? r_xb + w_off_x : r_xb - w_off_x;
        w_y_nxt    = w_side_nxt ? r_yb + w_off_y : r_yb - w_off_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xc <= '0; r_yc <= '0; r_xb <= '0; r_yb <= '0; r_mode <= 1'b0;
            r_cnt <= '0; r_cos <= '0; r_sin <= '0; r_acc_c <= '0; r_acc_s <= '0;
            r_k <= '0; r_beat <= '0; r_side <= 1'b0; r_last <= 1'b0;
            r_x <= '0; r_y <= '0; r_valid <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && in_valid) begin
                r_xc   <= xc;
                r_yc   <= yc;
                r_xb   <= xb;
                r_yb   <= yb;
                r_mode <= mode;
                r_cnt  <= '0;
            end
            if (r_state == ST_ANGLE && !w_angle_done) r_cnt <= r_cnt + CW'(1);
            if (w_angle_done) begin
                r_cos <= w_coef_c;
                r_sin <= w_coef_s;
            end
            if (w_load) begin
                r_acc_c <= w_acc_c_nxt;
                r_acc_s <= w_acc_s_nxt;
                r_k     <= w_k_nxt;
                r_beat  <= w_beat_nxt;
                r_side  <= w_side_nxt;
                r_last  <= w_last_nxt;
                r_x     <= w_x_nxt;
                r_y     <= w_y_nxt;
                r_valid <= 1'b1;
            end else if (w_fire && r_last) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_valid;
    assign out_x     = r_x;
    assign out_y     = r_y;
    assign out_idx   = r_k;
    assign out_side  = r_side;
    assign out_last  = r_last;

endmodule

// File: tb/tb_point_cal_stream.sv
// Directed bench for point_cal_stream: hand-computed beat sequences, latency,
// stall hold, wrap, floor on negative offsets and mid-stream reset.
module tb_point_cal_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] xc = '0, yc = '0, xb = '0, yb = '0;
    logic       mode = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] out_x, out_y;
    logic [2:0] out_idx;
    logic       out_side, out_last, busy;

    int n_vec = 0;
    int n_err = 0;
    int ex[8];
    int ey[8];

    point_cal_stream #(
        .WIDTH(10), .NPTS(4), .STEP(3), .COEF_W(10), .TRIG_LAT(4)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .xc(xc), .yc(yc), .xb(xb), .yb(yb), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_idx(out_idx),
        .out_side(out_side), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int ixc, input int iyc, input int ixb, input int iyb, input bit md);
        int lat;
        @(negedge clk);
        xc = 10'(ixc); yc = 10'(iyc); xb = 10'(ixb); yb = 10'(iyb); mode = md;
        in_valid = 1'b1;
        check("in_ready_before_accept", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        xc = 10'd7; yc = 10'd9; xb = 10'd511; yb = 10'd3; mode = ~md;
        check("in_ready_after_accept", int'(in_ready), 0);
        check("busy_after_accept", int'(busy), 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("first_valid_latency", lat, 5);
    endtask

    task automatic run_seq(input int n, input bit md, input bit stall, input bit final_chk);
        int  guard;
        bit  got, held;
        int  hx, hy, hi, hs, hl;
        time t_prev, t_now;
        t_prev = 0;
        for (int i = 0; i < n; i++) begin
            guard = 0; got = 1'b0; held = 1'b0;
            while (!got && guard < 100) begin
                @(negedge clk);
                guard++;
                if (held) begin
                    check("hold_valid", int'(out_valid), 1);
                    check("hold_x", int'(out_x), hx);
                    check("hold_y", int'(out_y), hy);
                    check("hold_idx", int'(out_idx), hi);
                    check("hold_side", int'(out_side), hs);
                    check("hold_last", int'(out_last), hl);
                end
                if (out_valid) begin
                    if (stall && $urandom_range(0, 1) == 0) begin
                        out_ready = 1'b0;
                        held = 1'b1;
                        hx = int'(out_x); hy = int'(out_y); hi = int'(out_idx);
                        hs = int'(out_side); hl = int'(out_last);
                    end else begin
                        check("beat_x", int'(out_x), ex[i]);
                        check("beat_y", int'(out_y), ey[i]);
                        check("beat_idx", int'(out_idx), md ? i + 1 : i / 2 + 1);
                        check("beat_side", int'(out_side), (md || i % 2 == 0) ? 1 : 0);
                        check("beat_last", int'(out_last), (final_chk && i == n - 1) ? 1 : 0);
                        out_ready = 1'b1;
                        got = 1'b1;
                    end
                end
            end
            if (!got) check("beat_timeout", 0, 1);
            @(posedge clk);
            t_now = $time;
            if (!stall && i > 0) check("beat_spacing", int'(t_now - t_prev), 10);
            t_prev = t_now;
            #1;
            out_ready = 1'b0;
        end
        if (final_chk) begin
            @(negedge clk);
            check("post_last_valid", int'(out_valid), 0);
            check("post_last_ready", int'(in_ready), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_x", int'(out_x), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // +x direction, both sides
        ex = '{303, 297, 306, 294, 309, 291, 312, 288};
        ey = '{200, 200, 200, 200, 200, 200, 200, 200};
        send(100, 200, 300, 200, 1'b0);
        run_seq(8, 1'b0, 1'b0, 1'b1);

        // +x direction, outer only
        ex = '{303, 306, 309, 312, 0, 0, 0, 0};
        send(100, 200, 300, 200, 1'b1);
        run_seq(4, 1'b1, 1'b0, 1'b1);

        // zero vector
        ex = '{50, 50, 50, 50, 50, 50, 50, 50};
        ey = '{60, 60, 60, 60, 60, 60, 60, 60};
        send(50, 60, 50, 60, 1'b0);
        run_seq(8, 1'b0, 1'b0, 1'b1);

        // +x direction with random downstream stalls
        ex = '{303, 297, 306, 294, 309, 291, 312, 288};
        ey = '{200, 200, 200, 200, 200, 200, 200, 200};
        send(100, 200, 300, 200, 1'b0);
        run_seq(8, 1'b0, 1'b1, 1'b1);

        // coordinate wrap near the top of the range
        ex = '{1023, 1017, 2, 1014, 5, 1011, 8, 1008};
        send(820, 200, 1020, 200, 1'b0);
        run_seq(8, 1'b0, 1'b0, 1'b1);

        // 45-degree diagonal, cos = sin = 181
        ex = '{202, 204, 206, 208, 0, 0, 0, 0};
        ey = '{202, 204, 206, 208, 0, 0, 0, 0};
        send(100, 100, 200, 200, 1'b1);
        run_seq(4, 1'b1, 1'b0, 1'b1);

        // -x direction
        ex = '{97, 94, 91, 88, 0, 0, 0, 0};
        ey = '{200, 200, 200, 200, 0, 0, 0, 0};
        send(300, 200, 100, 200, 1'b1);
        run_seq(4, 1'b1, 1'b0, 1'b1);

        // 225-degree diagonal: floor of negative offsets
        ex = '{97, 95, 93, 91, 0, 0, 0, 0};
        ey = '{97, 95, 93, 91, 0, 0, 0, 0};
        send(200, 200, 100, 100, 1'b1);
        run_seq(4, 1'b1, 1'b0, 1'b1);

        // reset during the third beat
        ex = '{303, 297, 306, 294, 309, 291, 312, 288};
        ey = '{200, 200, 200, 200, 200, 200, 200, 200};
        send(100, 200, 300, 200, 1'b0);
        run_seq(2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("third_beat_valid", int'(out_valid), 1);
        check("third_beat_x", int'(out_x), 306);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_x", int'(out_x), 0);
        check("midrst_out_y", int'(out_y), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_rst_quiet", int'(out_valid), 0);
        end
        out_ready = 1'b0;
        send(100, 200, 300, 200, 1'b0);
        run_seq(8, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
